// File: rtl/serial_accumulator8.sv
// Bit-serial accumulator: adds operand d into acc one full-adder slice per cycle, LSB first.
// Optional build macro SERIAL_ACC_SATURATE_EN clamps acc to all ones on carry-out.
module serial_accumulator8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic               r_cout;

    logic               w_sum_bit;
    logic               w_carry_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [WIDTH-1:0]   w_acc_final;
    logic               w_last;

    // One full-adder slice on the current LSBs.
    assign w_sum_bit    = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_carry_nxt  = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
    assign w_result_nxt = {w_sum_bit, r_result[WIDTH-1:1]};
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ACC_SATURATE_EN
    assign w_acc_final  = w_carry_nxt ? {WIDTH{1'b1}} : w_result_nxt;
`else
    assign w_acc_final  = w_result_nxt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!clr && start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // acc is only written on clr, rst, or the final slice, so it holds steady while shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_acc  <= '0;
                        r_cout <= 1'b0;
                    end else if (start) begin
                        r_op_a   <= d;
                        r_op_b   <= r_acc;
                        r_carry  <= 1'b0;
                        r_cnt    <= '0;
                        r_result <= '0;
                    end
                end
                S_SHIFT: begin
                    r_op_a   <= r_op_a >> 1;
                    r_op_b   <= r_op_b >> 1;
                    r_result <= w_result_nxt;
                    r_carry  <= w_carry_nxt;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_acc  <= w_acc_final;
                        r_cout <= w_carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign acc  = r_acc;
    assign cout = r_cout;

endmodule
